sb_fwd_queue: RTL and testbench

//  Parametrised speculative store buffer with byte-granular store-to-load forwarding.
//  - Sits between the dcache M1 stage, which enqueues translated stores, and the commit stage,

---
 rtl/sb_fwd_queue.sv | 125 ++++++++++++
 tb/tb_sb_fwd_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_fwd_queue.sv
// Speculative store buffer: in-order enqueue/commit/drain circular queue with
// byte-granular store-to-load forwarding and flush of uncommitted entries.
module sb_fwd_queue #(
    parameter  int SB_SIZE    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  enq_valid_i,
    output logic                  enq_ready_o,
    input  logic [ADDR_WIDTH-1:0] enq_addr_i,
    input  logic [DATA_WIDTH-1:0] enq_data_i,
    input  logic [STRB_W-1:0]     enq_strb_i,
    input  logic                  enq_unc_i,
    input  logic                  commit_i,
    output logic                  drn_valid_o,
    input  logic                  drn_ready_i,
    output logic [ADDR_WIDTH-1:0] drn_addr_o,
    output logic [DATA_WIDTH-1:0] drn_data_o,
    output logic [STRB_W-1:0]     drn_strb_o,
    output logic                  drn_unc_o,
    input  logic [ADDR_WIDTH-1:0] fwd_addr_i,
    output logic [STRB_W-1:0]     fwd_hit_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic                  fwd_unc_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PW  = $clog2(SB_SIZE);
    localparam int OFF = $clog2(STRB_W);

    logic [PW:0]           r_head, r_cmt, r_tail;
    logic [SB_SIZE-1:0]    r_vld;
    logic [ADDR_WIDTH-1:0] r_addr [SB_SIZE];
    logic [DATA_WIDTH-1:0] r_data [SB_SIZE];
    logic [STRB_W-1:0]     r_strb [SB_SIZE];
    logic [SB_SIZE-1:0]    r_unc;

    logic [PW:0]        w_count, w_head_n, w_cmt_n, w_tail_n, w_count_n;
    logic               w_full, w_enq, w_drn, w_cmt;
    logic [SB_SIZE-1:0] w_vld_n;
    logic [PW-1:0]      w_off;

    assign w_count = r_tail - r_head;
    assign w_full  = (w_count == (PW+1)'(SB_SIZE));
    assign w_drn   = (r_head != r_cmt) & drn_ready_i;
    assign w_cmt   = commit_i & (r_cmt != r_tail);
    // Readiness comes from the registered count, so a drain never frees a slot same-cycle.
    assign w_enq   = enq_valid_i & ~w_full & ~flush_i;

    assign w_head_n  = r_head + (PW+1)'(w_drn);
    assign w_cmt_n   = r_cmt + (PW+1)'(w_cmt);
    assign w_tail_n  = flush_i ? w_cmt_n : (r_tail + (PW+1)'(w_enq));
    assign w_count_n = w_tail_n - w_head_n;

    // Live-entry mask for next cycle, by slot distance from the new head.
    always_comb begin
        w_vld_n = '0;
        w_off   = '0;
        for (int i = 0; i < SB_SIZE; i++) begin
            w_off      = PW'(i) - w_head_n[PW-1:0];
            w_vld_n[i] = ({1'b0, w_off} < w_count_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
            r_vld  <= '0;
        end else begin
            r_head <= w_head_n;
            r_cmt  <= w_cmt_n;
            r_tail <= w_tail_n;
            r_vld  <= w_vld_n;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail[PW-1:0]] <= enq_addr_i;
            r_data[r_tail[PW-1:0]] <= enq_data_i;
            r_strb[r_tail[PW-1:0]] <= enq_strb_i;
            r_unc[r_tail[PW-1:0]]  <= enq_unc_i;
        end
    end

    assign enq_ready_o = ~w_full;
    assign full_o      = w_full;
    assign empty_o     = (w_count == '0);
    assign drn_valid_o = (r_head != r_cmt);
    assign drn_addr_o  = r_addr[r_head[PW-1:0]];
    assign drn_data_o  = r_data[r_head[PW-1:0]];
    assign drn_strb_o  = r_strb[r_head[PW-1:0]];
    assign drn_unc_o   = r_unc[r_head[PW-1:0]];

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    logic [PW-1:0] w_idx;
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        fwd_unc_o  = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < SB_SIZE; k++) begin
            w_idx = r_head[PW-1:0] + PW'(k);
            if (r_vld[w_idx] &&
                r_addr[w_idx][ADDR_WIDTH-1:OFF] == fwd_addr_i[ADDR_WIDTH-1:OFF]) begin
                if (r_unc[w_idx]) begin
                    fwd_unc_o = 1'b1;
                end else begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (r_strb[w_idx][b]) begin
                            fwd_hit_o[b]       = 1'b1;
                            fwd_data_o[8*b +: 8] = r_data[w_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sb_fwd_queue.sv
// Randomized + directed bench for sb_fwd_queue against a queue-based reference model.
module tb_sb_fwd_queue;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, enq_valid_i, enq_ready_o, enq_unc_i, commit_i;
    logic [31:0] enq_addr_i, enq_data_i, fwd_addr_i;
    logic [3:0]  enq_strb_i;
    logic        drn_valid_o, drn_ready_i, drn_unc_o;
    logic [31:0] drn_addr_o, drn_data_o, fwd_data_o;
    logic [3:0]  drn_strb_o, fwd_hit_o;
    logic        fwd_unc_o, full_o, empty_o;

    always #5 clk = ~clk;

    sb_fwd_queue dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i),
        .enq_strb_i(enq_strb_i), .enq_unc_i(enq_unc_i),
        .commit_i(commit_i),
        .drn_valid_o(drn_valid_o), .drn_ready_i(drn_ready_i),
        .drn_addr_o(drn_addr_o), .drn_data_o(drn_data_o),
        .drn_strb_o(drn_strb_o), .drn_unc_o(drn_unc_o),
        .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o),
        .fwd_data_o(fwd_data_o), .fwd_unc_o(fwd_unc_o),
        .full_o(full_o), .empty_o(empty_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: ordered list of live stores, the first ncmt of which are committed.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        u;
    } ent_t;
    ent_t q[$];
    int   ncmt = 0;

    task automatic check_model();
        logic [3:0]  eh;
        logic [31:0] ed;
        logic        eu;
        eh = '0; ed = '0; eu = 1'b0;
        foreach (q[k]) begin
            if (q[k].a[31:2] == fwd_addr_i[31:2]) begin
                if (q[k].u) eu = 1'b1;
                else for (int b = 0; b < 4; b++)
                    if (q[k].s[b]) begin
                        eh[b] = 1'b1;
                        ed[8*b +: 8] = q[k].d[8*b +: 8];
                    end
            end
        end
        chk("full", full_o, q.size() == N);
        chk("empty", empty_o, q.size() == 0);
        chk("enq_ready", enq_ready_o, q.size() < N);
        chk("drn_valid", drn_valid_o, ncmt > 0);
        if (ncmt > 0) begin
            chk("drn_addr", drn_addr_o, q[0].a);
            chk("drn_data", drn_data_o, q[0].d);
            chk("drn_strb", drn_strb_o, q[0].s);
            chk("drn_unc", drn_unc_o, q[0].u);
        end
        chk("fwd_hit", fwd_hit_o, eh);
        chk("fwd_data", fwd_data_o, ed);
        chk("fwd_unc", fwd_unc_o, eu);
    endtask

    task automatic update_model();
        bit   en;
        ent_t e;
        en = enq_valid_i && (q.size() < N) && !flush_i;
        if (drn_ready_i && ncmt > 0) begin
            void'(q.pop_front());
            ncmt--;
        end
        if (commit_i && ncmt < q.size()) ncmt++;
        if (flush_i) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end else if (en) begin
            e.a = enq_addr_i; e.d = enq_data_i; e.s = enq_strb_i; e.u = enq_unc_i;
            q.push_back(e);
        end
    endtask

    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic u, input logic cm,
                        input logic dr, input logic fl, input logic [31:0] fa);
        enq_valid_i = en; enq_addr_i = a; enq_data_i = d; enq_strb_i = s; enq_unc_i = u;
        commit_i = cm; drn_ready_i = dr; flush_i = fl; fwd_addr_i = fa;
        #2;
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle(input logic [31:0] fa);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, fa);
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic u);
        step(1'b1, a, d, s, u, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic probe(input logic [31:0] fa);
        fwd_addr_i = fa;
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 3 * N && q.size() > 0; i++)
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("drain_all_empty", empty_o, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 0; enq_valid_i = 0; enq_addr_i = 0; enq_data_i = 0; enq_strb_i = 0;
        enq_unc_i = 0; commit_i = 0; drn_ready_i = 0; fwd_addr_i = 0;
        #12;
        chk("rst_enq_ready", enq_ready_o, 1'b1);
        chk("rst_drn_valid", drn_valid_o, 1'b0);
        chk("rst_fwd_hit", fwd_hit_o, 4'h0);
        chk("rst_fwd_data", fwd_data_o, 32'h0);
        chk("rst_fwd_unc", fwd_unc_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_empty", empty_o, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill and wrap, three rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) enq(32'h100 + 32'(4*k), $urandom, 4'hF, 1'b0);
            chk("fill_full", full_o, 1'b1);
            chk("fill_ready", enq_ready_o, 1'b0);
            for (int k = 0; k < 4; k++)
                step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
            for (int k = 0; k < 4; k++) begin
                chk("fill_order", drn_addr_o, 32'h100 + 32'(4*k));
                // Enqueue attempt while full and draining must be dropped
                step(k == 0, 32'h7F0, 32'h55, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7F0);
                if (k == 0) chk("nobypass_full", full_o, 1'b0);
            end
            chk("fill_empty", empty_o, 1'b1);
        end

        // Byte merge
        enq(32'h200, 32'h11223344, 4'hF, 1'b0);
        enq(32'h200, 32'hAA000000, 4'h8, 1'b0);
        probe(32'h200);
        chk("merge_hit", fwd_hit_o, 4'hF);
        chk("merge_data", fwd_data_o, 32'hAA223344);
        probe(32'h204);
        chk("merge_miss", fwd_hit_o, 4'h0);
        drain_all();

        // Flush keeps committed entries
        enq(32'h500, 32'hA0A0A0A0, 4'hF, 1'b0);
        enq(32'h504, 32'hB0B0B0B0, 4'hF, 1'b0);
        enq(32'h508, 32'hC0C0C0C0, 4'hF, 1'b0);
        step(1'b1, 32'h50C, 32'hD0D0D0D0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
        probe(32'h504); chk("flush_fwdB", fwd_hit_o, 4'h0);
        probe(32'h508); chk("flush_fwdC", fwd_hit_o, 4'h0);
        probe(32'h50C); chk("flush_fwdD", fwd_hit_o, 4'h0);
        probe(32'h500); chk("flush_fwdA", fwd_hit_o, 4'hF);
        chk("flush_drnA", drn_addr_o, 32'h500);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500);
        chk("flush_one_left", empty_o, 1'b1);

        // Commit + flush same cycle
        enq(32'h600, 32'h01020304, 4'hF, 1'b0);
        enq(32'h604, 32'h05060708, 4'hF, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600);
        probe(32'h600); chk("cmtflush_A", fwd_hit_o, 4'hF);
        probe(32'h604); chk("cmtflush_B", fwd_hit_o, 4'h0);
        chk("cmtflush_drn", drn_valid_o, 1'b1);
        drain_all();

        // Uncached: replay and stable drain outputs under backpressure
        enq(32'h300, 32'hDEADBEEF, 4'hF, 1'b1);
        probe(32'h300);
        chk("unc_fwd_unc", fwd_unc_o, 1'b1);
        chk("unc_fwd_hit", fwd_hit_o, 4'h0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
        for (int k = 0; k < 5; k++) begin
            chk("unc_hold_valid", drn_valid_o, 1'b1);
            chk("unc_hold_addr", drn_addr_o, 32'h300);
            chk("unc_hold_data", drn_data_o, 32'hDEADBEEF);
            chk("unc_hold_unc", drn_unc_o, 1'b1);
            idle(32'h300);
        end
        drain_all();

        // Randomized traffic over a few words so forwarding hits and wraps often
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, 32'h400 + 32'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(1, 15)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, 32'h400 + 32'($urandom_range(0, 15)));
        end
        drain_all();

        // Asynchronous reset mid-operation
        enq(32'h800, 32'h11111111, 4'hF, 1'b0);
        enq(32'h804, 32'h22222222, 4'hF, 1'b0);
        enq(32'h808, 32'h33333333, 4'hF, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800);
        chk("prerst_drn_valid", drn_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        fwd_addr_i = 32'h804;
        #1;
        chk("arst_drn_valid", drn_valid_o, 1'b0);
        chk("arst_empty", empty_o, 1'b1);
        chk("arst_full", full_o, 1'b0);
        chk("arst_enq_ready", enq_ready_o, 1'b1);
        chk("arst_fwd_hit", fwd_hit_o, 4'h0);
        chk("arst_fwd_data", fwd_data_o, 32'h0);
        chk("arst_fwd_unc", fwd_unc_o, 1'b0);
        q.delete();
        ncmt = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(32'h804);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
